// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] base;
  logic [2*N-1:0] sel;

  // Subtracting the pointer bit from the doubled request clears the lowest
  // request at/above ptr; AND-NOT isolates exactly that bit in either half.
  assign dbl    = {req, req};
  assign base   = (2*N)'(1) << ptr;
  assign sel    = dbl & ~(dbl - base);
  assign win_oh = sel[N-1:0] | sel[2*N-1:N];

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_oh[i]) win_idx = win_idx | IW'(i);
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with transaction hold; owner keeps grant until done or req drop.
// Optional owner preemption after HOLD_MAX contended cycles: RR_HOLD_ARBITER_TIMEOUT_EN.
module rr_hold_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int unsigned N        = 8,
  parameter  int unsigned HOLD_MAX = 16,
  localparam int unsigned IW       = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic          grant_vld,
  output logic [IW-1:0] grant_id,
  output logic          timeout
);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          vld_q;

  logic [IW-1:0] nxt_ptr;
  logic          owner_rel;
  logic          rel;
  logic [N-1:0]  pick_req;
  logic [IW-1:0] pick_ptr;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;

  assign nxt_ptr   = (grant_id_q == IW'(N-1)) ? '0 : grant_id_q + IW'(1);
  assign owner_rel = (|(done & grant_q)) || !(|(req & grant_q));

  // In BUSY the picker pre-computes the successor with the owner masked off,
  // so a release can hand over without an idle cycle.
  assign pick_req = (state_q == BUSY) ? (req & ~grant_q) : req;
  assign pick_ptr = (state_q == BUSY) ? nxt_ptr : ptr_q;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_MAX) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          others_wait;

  assign others_wait = |(req & ~grant_q);
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX < 2);
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    rel        = 1'b0;
`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = win_oh;
          grant_id_d = win_idx;
          state_d    = BUSY;
`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        rel = owner_rel;
`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
        if (!rel && others_wait) begin
          if (cnt_q == CW'(HOLD_MAX - 1)) begin
            rel  = 1'b1;
            to_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        if (rel) begin
          ptr_d = nxt_ptr;
`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (|pick_req) begin
            grant_d    = win_oh;
            grant_id_d = win_idx;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      vld_q      <= |grant_d;
    end
  end

`ifdef RR_HOLD_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_vld = vld_q;
  assign grant_id  = grant_id_q;

endmodule
